// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Single-clock parametrised FIFO with occupancy count,
//                almost-full/almost-empty thresholds, registered read data
//                with a valid strobe, and sticky overflow/underflow flags.
//  Revision    : 1.0  - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 2,
    parameter int AFULL_THRESH  = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  c_DEPTH     = 1 << ADDR_WIDTH;
    localparam int                  c_IDX_W     = (ADDR_WIDTH > 0) ? ADDR_WIDTH : 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH+1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AFULL     = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_AEMPTY    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] c_ONE       = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_ZERO      = '0;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [c_IDX_W-1:0]    w_rd_idx;

    // The pointer MSB only disambiguates wrap laps; storage is addressed by the low bits.
    generate
        if (ADDR_WIDTH > 0) begin : g_idx_multi
            assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
            assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
        end else begin : g_idx_single
            assign w_wr_idx = '0;
            assign w_rd_idx = '0;
        end
    endgenerate

    assign w_empty  = (r_count == c_ZERO);
    assign w_full   = (r_count == c_DEPTH_CNT);
    assign w_wr_acc = wr & ~w_full;
    assign w_rd_acc = rd & ~w_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !reset) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end

            if (w_rd_acc) begin
                r_data_out <= r_mem[w_rd_idx];
                r_rd_ptr   <= r_rd_ptr + c_ONE;
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase

            // A fresh error outranks a clear requested in the same cycle.
            if (wr && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end

            if (rd && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign data_out     = r_data_out;
    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= c_AEMPTY);
    assign almost_full  = (r_count >= c_AFULL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Directed self-checking bench for sync_fifo_param with a
//                queue-based reference model compared every cycle.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_DW     = 8;
    localparam int c_AW     = 2;
    localparam int c_DEPTH  = 4;
    localparam int c_AFULL  = 3;
    localparam int c_AEMPTY = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr = 1'b0;
    logic            rd = 1'b0;
    logic            clr_err = 1'b0;
    logic [c_DW-1:0] data_in = '0;
    logic [c_DW-1:0] data_out;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic            almost_empty;
    logic            almost_full;
    logic [c_AW:0]   count;
    logic            overflow;
    logic            underflow;

    int vectors     = 0;
    int miscompares = 0;

    sync_fifo_param #(
        .DATA_WIDTH    (c_DW),
        .ADDR_WIDTH    (c_AW),
        .AFULL_THRESH  (c_AFULL),
        .AEMPTY_THRESH (c_AEMPTY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue holding the stored words, in arrival order.
    logic [c_DW-1:0] m_q[$];
    logic [c_DW-1:0] m_dout  = '0;
    logic            m_valid = 1'b0;
    logic            m_ovf   = 1'b0;
    logic            m_udf   = 1'b0;
    logic            m_init  = 1'b0;

    always @(posedge clk) begin
        int  sz;
        logic m_full;
        logic m_empty;
        if (reset) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_init  = 1'b1;
        end else begin
            sz      = m_q.size();
            m_full  = (sz == c_DEPTH);
            m_empty = (sz == 0);
            if (rd && !m_empty) begin
                m_dout  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (wr && !m_full) m_q.push_back(data_in);
            if (wr && m_full)   m_ovf = 1'b1;
            else if (clr_err)   m_ovf = 1'b0;
            if (rd && m_empty)  m_udf = 1'b1;
            else if (clr_err)   m_udf = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int sz;
        if (m_init) begin
            sz = m_q.size();
            chk("mdl_count",   32'(count),        32'(sz));
            chk("mdl_empty",   32'(empty),        32'(sz == 0));
            chk("mdl_full",    32'(full),         32'(sz == c_DEPTH));
            chk("mdl_aempty",  32'(almost_empty), 32'(sz <= c_AEMPTY));
            chk("mdl_afull",   32'(almost_full),  32'(sz >= c_AFULL));
            chk("mdl_ovf",     32'(overflow),     32'(m_ovf));
            chk("mdl_udf",     32'(underflow),    32'(m_udf));
            chk("mdl_rdvalid", 32'(rd_valid),     32'(m_valid));
            chk("mdl_dout",    32'(data_out),     32'(m_dout));
        end
    end

    // One clock of stimulus; returns just after the edge so outputs are settled.
    task automatic cyc(input logic t_rst, input logic t_wr, input logic t_rd,
                       input logic t_clr, input logic [c_DW-1:0] t_d);
        @(negedge clk);
        reset   = t_rst;
        wr      = t_wr;
        rd      = t_rd;
        clr_err = t_clr;
        data_in = t_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [c_DW-1:0] a [4];
        logic [c_DW-1:0] b [4];
        logic [c_DW-1:0] e_exp [5];
        a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        b = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        e_exp = '{8'hD1, 8'hD2, 8'hE1, 8'hE2, 8'hE3};

        // Reset held two cycles with wr/rd asserted
        cyc(1, 1, 1, 0, 8'h55);
        cyc(1, 1, 1, 0, 8'h55);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_dout",  32'(data_out), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_ovf",   32'(overflow), 0);
        chk("rst_udf",   32'(underflow), 0);

        // Fill
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, a[i]);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 3));
            chk("fill_full",  32'(full), 32'(i + 1 == 4));
        end
        cyc(0, 1, 0, 0, 8'hA5);
        chk("ovf_set",   32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);

        // Drain
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 8'h00);
            chk("drain_dout",  32'(data_out), 32'(a[i]));
            chk("drain_valid", 32'(rd_valid), 1);
        end
        chk("drain_empty", 32'(empty), 1);
        cyc(0, 0, 1, 0, 8'h00);
        chk("udf_set",   32'(underflow), 1);
        chk("udf_hold",  32'(data_out), 32'hA4);
        chk("udf_valid", 32'(rd_valid), 0);
        cyc(0, 0, 0, 1, 8'h00);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_udf", 32'(underflow), 0);

        // Wrap: 3 in/3 out, then fill across the pointer wrap
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'hC1 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 8'h00);
            chk("wrapc_dout", 32'(data_out), 32'(8'hC1 + 8'(i)));
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, b[i]);
        chk("wrap_full", 32'(full), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 8'h00);
            chk("wrapb_dout", 32'(data_out), 32'(b[i]));
        end

        // Simultaneous at count 2
        cyc(0, 1, 0, 0, 8'hD1);
        cyc(0, 1, 0, 0, 8'hD2);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 0, 8'hE1 + 8'(i));
            chk("sim_count", 32'(count), 2);
            chk("sim_dout",  32'(data_out), 32'(e_exp[i]));
        end
        cyc(0, 1, 0, 0, 8'hF1);
        cyc(0, 1, 0, 0, 8'hF2);
        chk("simf_full", 32'(full), 1);
        cyc(0, 1, 1, 0, 8'h61);
        chk("simf_count", 32'(count), 3);
        chk("simf_ovf",   32'(overflow), 1);
        chk("simf_dout",  32'(data_out), 32'hE4);
        cyc(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'h00);
        chk("sime_dout",  32'(data_out), 32'hF2);
        chk("sime_empty", 32'(empty), 1);
        cyc(0, 1, 1, 0, 8'h71);
        chk("sime_count", 32'(count), 1);
        chk("sime_udf",   32'(underflow), 1);
        chk("sime_valid", 32'(rd_valid), 0);

        // clr_err and reset mid-operation
        cyc(0, 0, 0, 1, 8'h00);
        chk("clr2_udf", 32'(underflow), 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'h81 + 8'(i));
        chk("clr_full", 32'(full), 1);
        cyc(0, 1, 0, 1, 8'h99);
        chk("clrwin_ovf", 32'(overflow), 1);
        chk("clrwin_cnt", 32'(count), 4);
        cyc(0, 0, 1, 0, 8'h00);
        chk("mid_count", 32'(count), 3);
        chk("mid_dout",  32'(data_out), 32'h71);
        cyc(1, 0, 0, 0, 8'h00);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_ovf",   32'(overflow), 0);
        cyc(0, 0, 1, 0, 8'h00);
        chk("post_udf",   32'(underflow), 1);
        chk("post_count", 32'(count), 0);
        cyc(0, 0, 0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
